ahb_split_slave_ctrl: RTL and testbench

- Slave-side SPLIT controller placed between the AHB slave interface and one shared, slow backend resource (e.g. a flash or bridge engine).
- Owns HREADYOUT, HRESP and HSPLIT for that slave:
  - accepts transfers when the backend is free;
  - issues two-cycle SPLIT responses when it is busy or slow, and records the splitting masters;
  - releases them round-robin through HSPLIT so the system arbiter can regrant them.

---
 rtl/ahb_params_pkg.sv | 42 ++++
 rtl/ahb_split_slave_ctrl_if.sv | 26 ++
 rtl/ahb_split_slave_ctrl_rr_pick.sv | 31 +++
 rtl/ahb_split_slave_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_ahb_split_slave_ctrl.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_params_pkg.sv
// Shared AHB parameters and enums for the slave-side SPLIT controller and arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahb_params_pkg;

    // Number of bus masters; width of HSPLIT and of the pending mask.
    localparam int NO_OF_MASTERS = 2;
    localparam int HMASTER_W     = 4;
    // Index width for a master number inside the controller (at least one bit).
    localparam int MST_IDX_W     = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;

    // Defaults for the split controller timing knobs.
    localparam int MAX_WAIT_DEF    = 8;
    localparam int RSV_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_DATA_WAIT = 2'b01,
        ST_RESP1     = 2'b10,
        ST_RESP2     = 2'b11
    } split_st_e;

    // True for transfer types that carry a real address phase.
    function automatic logic is_active_trans(input htrans_e t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_split_slave_ctrl_if.sv
// AHB slave-side signal bundle for the SPLIT controller (select, transfer, ready, response, split release).
// Latency: n/a (wiring only).
// Backpressure: HREADYOUT low stalls the bus; HSPLIT pulses let the arbiter regrant split masters.
// Ports: master modport drives HSEL/HTRANS/HREADY/HMASTER; slave modport drives HREADYOUT/HRESP/HSPLIT.
interface ahb_split_slave_ctrl_if;
    import ahb_params_pkg::*;

    logic                      HSEL;
    htrans_e                   HTRANS;
    logic                      HREADY;
    logic [HMASTER_W-1:0]      HMASTER;
    logic                      HREADYOUT;
    hresp_e                    HRESP;
    logic [NO_OF_MASTERS-1:0]  HSPLIT;

    modport master (
        output HSEL, HTRANS, HREADY, HMASTER,
        input  HREADYOUT, HRESP, HSPLIT
    );

    modport slave (
        input  HSEL, HTRANS, HREADY, HMASTER,
        output HREADYOUT, HRESP, HSPLIT
    );

endinterface

// File: rtl/ahb_split_slave_ctrl_rr_pick.sv
// Round-robin first-set-bit finder: searches mask upward from ptr with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; vld is low when mask is empty (idx is then 0).
// Ports: mask/ptr in, idx/vld out.
module rr_pick #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         vld
);

    // Walk offsets from the far end back to ptr so the nearest set bit
    // (smallest offset from ptr) is the last one written and therefore wins.
    always_comb begin
        logic [W-1:0] pos;
        pos = '0;
        idx = '0;
        vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = W'((int'(ptr) + k) % N);
            if (mask[pos]) begin
                idx = pos;
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_split_slave_ctrl.sv
// SPLIT controller for one AHB slave fronting a single slow backend; owns HREADYOUT/HRESP/HSPLIT.
// Latency: accepted transfer starts the backend in the address cycle; ERROR/SPLIT answered as RESP1+RESP2.
// Backpressure: holds HREADYOUT low while waiting (max MAX_WAIT cycles), then SPLITs; split masters released round-robin.
// Ports: HCLK, HRESETn; ahb (slave modport); bk_busy/bk_done from backend, bk_start pulse to backend.
module ahb_split_slave_ctrl
    import ahb_params_pkg::*;
#(
    parameter int MAX_WAIT    = MAX_WAIT_DEF,
    parameter int RSV_TIMEOUT = RSV_TIMEOUT_DEF
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_split_slave_ctrl_if.slave ahb,
    input  logic                  bk_busy,
    output logic                  bk_start,
    input  logic                  bk_done
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam int RCW = $clog2(RSV_TIMEOUT + 1);
    localparam logic [NO_OF_MASTERS-1:0] ONE_HOT0 = NO_OF_MASTERS'(1);

    split_st_e                state, state_nxt;
    hresp_e                   resp_code, resp_code_nxt;
    logic [NO_OF_MASTERS-1:0] pend_mask;
    logic [MST_IDX_W-1:0]     rr_ptr;
    logic [MST_IDX_W-1:0]     owner;
    logic                     rsv_valid;
    logic [MST_IDX_W-1:0]     rsv_master;
    logic [RCW-1:0]           rsv_cnt;
    logic [WCW-1:0]           wait_cnt;
    logic [NO_OF_MASTERS-1:0] hsplit_q;

    logic                     accept;
    logic                     mst_ok;
    logic [MST_IDX_W-1:0]     mst_idx;
    logic                     rsv_block;
    logic                     wait_last;
    logic                     rsv_last;
    logic                     start_xfer;
    logic                     do_release;
    logic [NO_OF_MASTERS-1:0] pend_set;
    logic [MST_IDX_W-1:0]     pick_idx;
    logic                     pick_vld;
    logic                     hready_c;
    hresp_e                   hresp_c;

    assign accept    = ahb.HSEL && ahb.HREADY && is_active_trans(ahb.HTRANS);
    assign mst_ok    = ahb.HMASTER < HMASTER_W'(NO_OF_MASTERS);
    assign mst_idx   = ahb.HMASTER[MST_IDX_W-1:0];
    // A live reservation turns away every master except the one just released.
    assign rsv_block = rsv_valid && (ahb.HMASTER != HMASTER_W'(rsv_master));
    assign wait_last = (wait_cnt == WCW'(MAX_WAIT - 1));
    assign rsv_last  = (rsv_cnt == RCW'(RSV_TIMEOUT - 1));

    rr_pick #(
        .N (NO_OF_MASTERS),
        .W (MST_IDX_W)
    ) u_rr_pick (
        .mask (pend_mask),
        .ptr  (rr_ptr),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            resp_code <= HRESP_OKAY;
        end else begin
            state     <= state_nxt;
            resp_code <= resp_code_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM next-state and outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        resp_code_nxt = resp_code;
        start_xfer    = 1'b0;
        do_release    = 1'b0;
        pend_set      = '0;
        hready_c      = 1'b1;
        hresp_c       = HRESP_OKAY;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!mst_ok) begin
                        state_nxt     = ST_RESP1;
                        resp_code_nxt = HRESP_ERROR;
                    end else if (bk_busy || rsv_block) begin
                        state_nxt     = ST_RESP1;
                        resp_code_nxt = HRESP_SPLIT;
                        pend_set      = ONE_HOT0 << mst_idx;
                    end else begin
                        start_xfer    = 1'b1;
                        state_nxt     = ST_DATA_WAIT;
                    end
                end else if (!bk_busy && !rsv_valid) begin
                    // Release only on a quiet cycle, so a master can never be
                    // split and released in the same cycle.
                    do_release = pick_vld;
                end
            end

            ST_DATA_WAIT: begin
                hready_c = 1'b0;
                if (bk_done) begin
                    state_nxt = ST_IDLE;
                end else if (wait_last) begin
                    state_nxt     = ST_RESP1;
                    resp_code_nxt = HRESP_SPLIT;
                    pend_set      = ONE_HOT0 << owner;
                end
            end

            ST_RESP1: begin
                hready_c  = 1'b0;
                hresp_c   = resp_code;
                state_nxt = ST_RESP2;
            end

            ST_RESP2: begin
                // Address phases seen here are cancelled by the master; ignore them.
                hready_c  = 1'b1;
                hresp_c   = resp_code;
                state_nxt = ST_IDLE;
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath: wait counter, owner, pending mask, release, reservation
    // ---------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wait_cnt   <= '0;
            owner      <= '0;
            pend_mask  <= '0;
            rr_ptr     <= '0;
            hsplit_q   <= '0;
            rsv_valid  <= 1'b0;
            rsv_master <= '0;
            rsv_cnt    <= '0;
        end else begin
            if (start_xfer || (state != ST_DATA_WAIT)) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WCW'(1);
            end

            if (start_xfer) begin
                owner <= mst_idx;
            end

            pend_mask <= (pend_mask | pend_set)
                       & ~(do_release ? (ONE_HOT0 << pick_idx) : '0);

            hsplit_q <= do_release ? (ONE_HOT0 << pick_idx) : '0;

            if (do_release) begin
                rr_ptr <= (int'(pick_idx) == NO_OF_MASTERS - 1) ? '0
                                                                : pick_idx + MST_IDX_W'(1);
            end

            // An accepted transfer always belongs to the reserved master (or
            // no reservation exists), so it simply ends the reservation.
            if (start_xfer) begin
                rsv_valid <= 1'b0;
                rsv_cnt   <= '0;
            end else if (do_release) begin
                rsv_valid  <= 1'b1;
                rsv_master <= pick_idx;
                rsv_cnt    <= '0;
            end else if (rsv_valid) begin
                if (rsv_last) begin
                    rsv_valid <= 1'b0;
                    rsv_cnt   <= '0;
                end else begin
                    rsv_cnt <= rsv_cnt + RCW'(1);
                end
            end
        end
    end

    assign ahb.HREADYOUT = hready_c;
    assign ahb.HRESP     = hresp_c;
    assign ahb.HSPLIT    = hsplit_q;
    assign bk_start      = start_xfer;

endmodule

// File: tb/tb_ahb_split_slave_ctrl.sv
// Directed bench for ahb_split_slave_ctrl: accept path, busy SPLIT, round-robin release,
// reservation timeout/blocking, MAX_WAIT split, ERROR response and mid-transfer reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled 3 units after it.
module tb_ahb_split_slave_ctrl;
    import ahb_params_pkg::*;

    logic HCLK;
    logic HRESETn;
    logic bk_busy;
    logic bk_start;
    logic bk_done;

    int checks;
    int errors;
    int n;
    int lo;
    int seen;

    ahb_split_slave_ctrl_if bus ();

    ahb_split_slave_ctrl dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .ahb      (bus.slave),
        .bk_busy  (bk_busy),
        .bk_start (bk_start),
        .bk_done  (bk_done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_bus;
        bus.HSEL    = 1'b0;
        bus.HTRANS  = HTRANS_IDLE;
        bus.HREADY  = 1'b1;
        bus.HMASTER = '0;
    endtask

    task automatic addr(input logic [HMASTER_W-1:0] m);
        bus.HSEL    = 1'b1;
        bus.HTRANS  = HTRANS_NONSEQ;
        bus.HREADY  = 1'b1;
        bus.HMASTER = m;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        idle_bus();
        bk_busy = 1'b0;
        bk_done = 1'b0;
        HRESETn = 1'b0;
        repeat (2) @(posedge HCLK);
        #3;

        // ---------------- reset values
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 1);
        chk("rst_hresp",     32'(bus.HRESP), HRESP_OKAY);
        chk("rst_hsplit",    32'(bus.HSPLIT), 0);
        chk("rst_bk_start",  32'(bk_start), 0);
        chk("rst_pend",      32'(dut.pend_mask), 0);
        chk("rst_rr_ptr",    32'(dut.rr_ptr), 0);
        chk("rst_rsv_valid", 32'(dut.rsv_valid), 0);
        chk("rst_wait_cnt",  32'(dut.wait_cnt), 0);
        chk("rst_state",     32'(dut.state), ST_IDLE);
        cyc();
        HRESETn = 1'b1;
        cyc();

        // ---------------- BUSY with HSEL: zero-wait OKAY, no backend start
        bus.HSEL   = 1'b1;
        bus.HTRANS = HTRANS_BUSY;
        #2;
        chk("busy_hreadyout", 32'(bus.HREADYOUT), 1);
        chk("busy_hresp",     32'(bus.HRESP), HRESP_OKAY);
        chk("busy_bk_start",  32'(bk_start), 0);
        cyc();

        // ---------------- master 0, backend free, done 3 cycles after start
        addr(0);
        #2;
        chk("t1_bk_start", 32'(bk_start), 1);
        chk("t1_addr_hro", 32'(bus.HREADYOUT), 1);
        cyc();
        idle_bus();
        #2;
        chk("t1_w1_hro",   32'(bus.HREADYOUT), 0);
        chk("t1_w1_start", 32'(bk_start), 0);
        chk("t1_w1_resp",  32'(bus.HRESP), HRESP_OKAY);
        cyc();
        #2;
        chk("t1_w2_hro", 32'(bus.HREADYOUT), 0);
        cyc();
        bk_done = 1'b1;
        #2;
        chk("t1_w3_hro", 32'(bus.HREADYOUT), 0);
        cyc();
        bk_done = 1'b0;
        #2;
        chk("t1_done_hro",    32'(bus.HREADYOUT), 1);
        chk("t1_done_resp",   32'(bus.HRESP), HRESP_OKAY);
        chk("t1_done_hsplit", 32'(bus.HSPLIT), 0);
        cyc();

        // ---------------- busy backend: master 1 split, then released
        bk_busy = 1'b1;
        addr(1);
        #2;
        chk("t2_no_start", 32'(bk_start), 0);
        cyc();
        idle_bus();
        #2;
        chk("t2_r1_hro",  32'(bus.HREADYOUT), 0);
        chk("t2_r1_resp", 32'(bus.HRESP), HRESP_SPLIT);
        cyc();
        #2;
        chk("t2_r2_hro",  32'(bus.HREADYOUT), 1);
        chk("t2_r2_resp", 32'(bus.HRESP), HRESP_SPLIT);
        cyc();
        #2;
        chk("t2_pend",        32'(dut.pend_mask), 2'b10);
        chk("t2_hsplit_busy", 32'(bus.HSPLIT), 0);
        bk_busy = 1'b0;
        cyc();
        #2;
        chk("t2_hsplit",    32'(bus.HSPLIT), 2'b10);
        chk("t2_pend_clr",  32'(dut.pend_mask), 0);
        chk("t2_rsv_valid", 32'(dut.rsv_valid), 1);
        chk("t2_rr_ptr",    32'(dut.rr_ptr), 0);
        cyc();
        #2;
        chk("t2_hsplit_once", 32'(bus.HSPLIT), 0);
        // Reserved master 1 comes back and is accepted.
        addr(1);
        #1;
        chk("t2_rsv_accept", 32'(bk_start), 1);
        cyc();
        idle_bus();
        bk_done = 1'b1;
        #2;
        chk("t2_rsv_cleared", 32'(dut.rsv_valid), 0);
        cyc();
        bk_done = 1'b0;
        cyc();

        // ---------------- both masters split, round-robin release and timeout
        bk_busy = 1'b1;
        addr(0);
        cyc();
        idle_bus();
        cyc();
        cyc();
        addr(1);
        cyc();
        idle_bus();
        cyc();
        cyc();
        #2;
        chk("t3_pend",   32'(dut.pend_mask), 2'b11);
        chk("t3_rr_ptr", 32'(dut.rr_ptr), 0);
        bk_busy = 1'b0;
        cyc();
        #2;
        chk("t3_hsplit0", 32'(bus.HSPLIT), 2'b01);
        chk("t3_rr_ptr1", 32'(dut.rr_ptr), 1);
        cyc();
        #2;
        chk("t3_hsplit0_once", 32'(bus.HSPLIT), 0);
        // 16 reserved cycles elapse, then one quiet cycle releases master 1.
        n = 1;
        while (bus.HSPLIT !== 2'b10 && n < 40) begin
            cyc();
            #2;
            n++;
        end
        chk("t3_timeout_gap", 32'(n), 17);
        chk("t3_hsplit1",     32'(bus.HSPLIT), 2'b10);
        chk("t3_rr_ptr0",     32'(dut.rr_ptr), 0);
        chk("t3_pend_empty",  32'(dut.pend_mask), 0);
        cyc();

        // ---------------- reserved for master 1: master 0 is split again
        addr(0);
        #2;
        chk("t4_blocked_start", 32'(bk_start), 0);
        cyc();
        idle_bus();
        #2;
        chk("t4_r1_hro",  32'(bus.HREADYOUT), 0);
        chk("t4_r1_resp", 32'(bus.HRESP), HRESP_SPLIT);
        cyc();
        cyc();
        #2;
        chk("t4_pend",      32'(dut.pend_mask), 2'b01);
        chk("t4_rsv_still", 32'(dut.rsv_valid), 1);
        addr(1);
        #1;
        chk("t4_owner_start", 32'(bk_start), 1);
        cyc();
        idle_bus();
        #2;
        chk("t4_rsv_cleared", 32'(dut.rsv_valid), 0);

        // ---------------- no bk_done: 8 wait cycles then SPLIT for owner 1
        lo = 0;
        repeat (8) begin
            if (bus.HREADYOUT === 1'b0 && bus.HRESP === HRESP_OKAY) lo++;
            cyc();
            #2;
        end
        chk("t5_wait_cycles", 32'(lo), 8);
        chk("t5_r1_hro",      32'(bus.HREADYOUT), 0);
        chk("t5_r1_resp",     32'(bus.HRESP), HRESP_SPLIT);
        bk_busy = 1'b1;
        cyc();
        #2;
        chk("t5_r2_hro",  32'(bus.HREADYOUT), 1);
        chk("t5_r2_resp", 32'(bus.HRESP), HRESP_SPLIT);
        cyc();
        #2;
        chk("t5_pend", 32'(dut.pend_mask), 2'b11);

        // ---------------- out-of-range master: two-cycle ERROR
        addr(5);
        #1;
        chk("t6_no_start", 32'(bk_start), 0);
        cyc();
        idle_bus();
        #2;
        chk("t6_r1_hro",  32'(bus.HREADYOUT), 0);
        chk("t6_r1_resp", 32'(bus.HRESP), HRESP_ERROR);
        cyc();
        #2;
        chk("t6_r2_hro",  32'(bus.HREADYOUT), 1);
        chk("t6_r2_resp", 32'(bus.HRESP), HRESP_ERROR);
        cyc();
        #2;
        chk("t6_idle_resp", 32'(bus.HRESP), HRESP_OKAY);
        chk("t6_pend",      32'(dut.pend_mask), 2'b11);

        // ---------------- reset during DATA_WAIT
        bk_busy = 1'b0;
        addr(0);
        #1;
        chk("t7_start", 32'(bk_start), 1);
        cyc();
        idle_bus();
        #2;
        chk("t7_dw_hro", 32'(bus.HREADYOUT), 0);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("t7_rst_hro",    32'(bus.HREADYOUT), 1);
        chk("t7_rst_resp",   32'(bus.HRESP), HRESP_OKAY);
        chk("t7_rst_hsplit", 32'(bus.HSPLIT), 0);
        chk("t7_rst_pend",   32'(dut.pend_mask), 0);
        chk("t7_rst_state",  32'(dut.state), ST_IDLE);
        cyc();
        cyc();
        HRESETn = 1'b1;
        seen = 0;
        repeat (4) begin
            cyc();
            #2;
            if (bus.HSPLIT !== '0) seen++;
        end
        chk("t7_no_release", 32'(seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
